row_scanout: RTL and testbench
==============================

Name: row_scanout

Overview:
- Display-side consumer of the ping-pong row buffer filled by the row drawer.
- Generates 640x480@60 VGA timing on the pixel clock and reads the currently displayed row bank pixel by pixel.
- Drives RGB, sync and data-enable, and issues the one-cycle `swap` pulse that hands the other bank to the drawer.
- Sits between the row-buffer RAMs and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FIELD_W, 480, pixel columns sourced from the row buffer (columns 0..FIELD_W-1)
- BORDER_RGB, 24'h202020, colour for visible columns >= FIELD_W

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- rst_n  in  1  asynchronous active-low reset
- row_addr  out  9  read address into displayed bank
- row_data  in  24  read data; RAM registered read, 1-cycle latency
- bank_sel  out  1  bank being displayed; drawer writes ~bank_sel
- clr_addr  out  9  clear-port write address (displayed bank)
- clr_wren  out  1  clear-port write enable (data is always 24'h0)
- swap  out  1  one-cycle pulse: drawer restarts on next row
- vga_rgb  out  24  {R[23:16],G[15:8],B[7:0]}
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  visible-pixel enable
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0

Behaviour:
- Reset values:
  - Counters: hcount=0, vcount=0.
  - Outputs: bank_sel=0, swap=0, clr_wren=0, row_addr=0, clr_addr=0, vga_rgb=0, vga_hs=1, vga_vs=1, vga_de=0, frame_start=0.
  - The delay pipeline clears to the same inactive values.
- Counters:
  - hcount runs 0..H_TOTAL-1, where H_TOTAL=800.
  - vcount increments when hcount wraps and runs 0..V_TOTAL-1, where V_TOTAL=525.
  - Both wrap to 0; widths are 10 bits.
- Stage 0 (counter stage):
  - row_addr = hcount[8:0] when hcount<FIELD_W, else 0.
  - vis0 = (hcount<H_ACTIVE)&(vcount<V_ACTIVE).
  - fld0 = vis0&(hcount<FIELD_W).
- Stage 1: vis, fld, hs and vs are registered alongside the outstanding RAM read.
- Stage 2 (output registers):
  - vga_rgb = fld ? row_data : (vis ? BORDER_RGB : 0).
  - vga_de = vis.
  - vga_hs is low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vga_vs is low for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - hs/vs are delayed identically, so every output has a fixed 2-cycle latency from its counter value.
- swap:
  - Asserted for exactly one cycle when hcount==H_ACTIVE+2, after the last read data of the line has been consumed.
  - Asserted only for vcount in 0..V_ACTIVE-2 and for vcount==V_TOTAL-1.
  - Gives exactly V_ACTIVE (480) pulses per frame; the pulse at line V_TOTAL-1 prepares row 0.
- bank_sel toggles on the same cycle swap is registered high. swap and the toggle are never split across cycles.
- frame_start is a registered pulse when hcount==0 && vcount==0; it is not pipeline-delayed.
- Reset mid-line: all state returns to reset values immediately. The first swap after reset occurs on line 0.
- No handshake or backpressure: the drawer must finish within one line time (800 cycles).

Optional Feature:
- Macro SCANOUT_CLEAR_EN.
- Defined:
  - One cycle after each field read (stage 1 with fld=1), clr_wren=1 and clr_addr=the stage-1 address.
  - This zeroes the pixel just read, so the bank is transparent-black when it is next handed to the drawer.
  - The read of an address always precedes its clear by one cycle.
- Undefined: clr_wren is tied 0 and clr_addr is tied 0, and the drawer or other logic owns clearing.

Decomposition:
- Shared package (vga_pkg):
  - Timing constants H_*/V_* and the derived H_TOTAL/V_TOTAL.
  - RGB24 width.
  - ROW_ADDR_W=9.
  - FIELD_W, also used by the row drawer and the entity logic.
- One natural sub-module, vga_timing:
  - Contents: the counters plus the hs/vs/vis/frame_start generation.
  - row_scanout adds the read pipeline, bank control, swap and clear logic.

Test Plan:
- Reset released -> vga_hs=1, vga_vs=1, vga_de=0. The first frame_start is on the first cycle with hcount=0, vcount=0. Frame period is 420000 cycles.
- Bank preloaded with row_data = address → for line 0, vga_rgb at pixel 5 equals 24'h000005, appearing 2 cycles after hcount=5. Pixels 480..639 equal 24'h202020; blanking equals 0.
- Count swap pulses over one frame → exactly 480. Each pulse is at hcount=642, on vcount 0..478 and 524. bank_sel toggles on each pulse; swap is never 2 cycles wide.
- Sync check → hsync low for 96 cycles starting 2 cycles after hcount=656. vsync low for lines 490-491. vga_de is high for exactly 640x480 cycles per frame.
- SCANOUT_CLEAR_EN defined → for each field pixel n, clr_wren=1 and clr_addr=n exactly one cycle after row_addr=n. That gives 480 clears per visible line and none in blanking. Undefined → clr_wren is never 1.
- rst_n low at hcount=300, vcount=100 for 3 cycles → outputs return to reset values asynchronously. The next swap is at line 0, hcount=642, and bank_sel=0 beforehand.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
//  Module   : vga_pkg
//  Brief    : 640x480@60 VGA timing constants and shared row-buffer types.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W      = 10;
  localparam int RGB_W      = 24;
  localparam int ROW_ADDR_W = 9;
  localparam int FIELD_W    = 480;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [RGB_W-1:0]      rgb_t;
  typedef logic [ROW_ADDR_W-1:0] row_addr_t;

  localparam rgb_t BORDER_RGB = 24'h202020;

  typedef struct packed {
    logic vis;
    logic fld;
    logic hs;
    logic vs;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{vis: 1'b0, fld: 1'b0, hs: 1'b1, vs: 1'b1};

  // True while c lies in the half-open window [lo, lo+len).
  function automatic logic in_window(cnt_t c, int lo, int len);
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_scanout_if.sv
// ============================================================================
//  Module   : row_scanout_if
//  Brief    : Row-buffer read/clear port plus VGA pin bundle for row_scanout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface row_scanout_if;
  import vga_pkg::*;

  row_addr_t row_addr;
  rgb_t      row_data;
  logic      bank_sel;
  row_addr_t clr_addr;
  logic      clr_wren;
  logic      swap;
  rgb_t      vga_rgb;
  logic      vga_hs;
  logic      vga_vs;
  logic      vga_de;
  logic      frame_start;

  modport master (
    output row_addr, bank_sel, clr_addr, clr_wren, swap,
    output vga_rgb, vga_hs, vga_vs, vga_de, frame_start,
    input  row_data
  );

  modport slave (
    input  row_addr, bank_sel, clr_addr, clr_wren, swap,
    input  vga_rgb, vga_hs, vga_vs, vga_de, frame_start,
    output row_data
  );

endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
//  Module   : vga_timing
//  Brief    : Pixel/line counters with undelayed visible, hsync and vsync flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          rst_n,
  output vga_pkg::cnt_t hcount,
  output vga_pkg::cnt_t vcount,
  output logic          vis,
  output logic          hs,
  output logic          vs,
  output logic          frame_start
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic w_h_last;
  logic w_v_last;

  assign w_h_last = (hcount == cnt_t'(H_TOTAL - 1));
  assign w_v_last = (vcount == cnt_t'(V_TOTAL - 1));

  // frame_start is decoded one count early so it lines up with (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_h_last && w_v_last;
      if (w_h_last) begin
        hcount <= '0;
        vcount <= w_v_last ? '0 : vcount + cnt_t'(1);
      end else begin
        hcount <= hcount + cnt_t'(1);
      end
    end
  end

  assign vis = (hcount < cnt_t'(H_ACTIVE)) && (vcount < cnt_t'(V_ACTIVE));
  assign hs  = !in_window(hcount, H_ACTIVE + H_FP, H_SYNC);
  assign vs  = !in_window(vcount, V_ACTIVE + V_FP, V_SYNC);

endmodule

`default_nettype wire

// File: rtl/row_scanout.sv
// ============================================================================
//  Module   : row_scanout
//  Brief    : Scans the displayed row bank out to VGA and hands banks to the
//             drawer. Define SCANOUT_CLEAR_EN to zero each pixel after reading.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_scanout #(
  parameter int            H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int            H_FP       = vga_pkg::H_FP,
  parameter int            H_SYNC     = vga_pkg::H_SYNC,
  parameter int            H_BP       = vga_pkg::H_BP,
  parameter int            V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int            V_FP       = vga_pkg::V_FP,
  parameter int            V_SYNC     = vga_pkg::V_SYNC,
  parameter int            V_BP       = vga_pkg::V_BP,
  parameter int            FIELD_W    = vga_pkg::FIELD_W,
  parameter vga_pkg::rgb_t BORDER_RGB = vga_pkg::BORDER_RGB
) (
  input  logic          clk,
  input  logic          rst_n,
  row_scanout_if.master bus
);
  import vga_pkg::*;

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  cnt_t      w_hcount;
  cnt_t      w_vcount;
  logic      w_vis0;
  logic      w_hs0;
  logic      w_vs0;
  logic      w_frame_start;
  logic      w_in_field;
  logic      w_fld0;
  row_addr_t w_addr0;
  logic      w_swap_d;

  pipe_t     r_s1;
  rgb_t      r_rgb;
  logic      r_hs;
  logic      r_vs;
  logic      r_de;
  logic      r_swap;
  logic      r_bank;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount      (w_hcount),
    .vcount      (w_vcount),
    .vis         (w_vis0),
    .hs          (w_hs0),
    .vs          (w_vs0),
    .frame_start (w_frame_start)
  );

  assign w_in_field = (w_hcount < cnt_t'(FIELD_W));
  assign w_fld0     = w_vis0 && w_in_field;
  assign w_addr0    = w_in_field ? w_hcount[ROW_ADDR_W-1:0] : '0;

  // Decoded one pixel early so the registered pulse lands on H_ACTIVE+2, after
  // the line's last read; the last-line pulse prepares row 0 of the next frame.
  assign w_swap_d = (w_hcount == cnt_t'(H_ACTIVE + 1)) &&
                    ((w_vcount <= cnt_t'(V_ACTIVE - 2)) ||
                     (w_vcount == cnt_t'(V_TOTAL - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= PIPE_IDLE;
      r_rgb  <= '0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_de   <= 1'b0;
      r_swap <= 1'b0;
      r_bank <= 1'b0;
    end else begin
      r_s1   <= '{vis: w_vis0, fld: w_fld0, hs: w_hs0, vs: w_vs0};
      r_rgb  <= r_s1.fld ? bus.row_data : (r_s1.vis ? BORDER_RGB : '0);
      r_hs   <= r_s1.hs;
      r_vs   <= r_s1.vs;
      r_de   <= r_s1.vis;
      r_swap <= w_swap_d;
      r_bank <= r_bank ^ w_swap_d;
    end
  end

  assign bus.row_addr    = w_addr0;
  assign bus.bank_sel    = r_bank;
  assign bus.swap        = r_swap;
  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_de      = r_de;
  assign bus.frame_start = w_frame_start;

`ifdef SCANOUT_CLEAR_EN
  row_addr_t r_addr1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr1 <= '0;
    end else begin
      r_addr1 <= w_addr0;
    end
  end

  // Clear trails the read by one cycle, so the pixel is never zeroed early.
  assign bus.clr_wren = r_s1.fld;
  assign bus.clr_addr = r_s1.fld ? r_addr1 : '0;
`else
  assign bus.clr_wren = 1'b0;
  assign bus.clr_addr = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_row_scanout.sv
// ============================================================================
//  Module   : tb_row_scanout
//  Brief    : Self-checking bench for row_scanout on a reduced raster.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_row_scanout;

  localparam int HA = 40;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int FW = 30;
  localparam int HT = HA + HF + HS + HB;   // 58
  localparam int VT = VA + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 1102
  localparam logic [23:0] BORDER = 24'h202020;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          epoch = 0;
  int          k     = 0;
  logic        mbank = 1'b0;
  logic [23:0] rd_hist [4];
  logic [23:0] mem [2][512];
  int          checks = 0;
  int          passes = 0;
  int          n_swap = 0;
  int          n_de   = 0;
  int          n_hs   = 0;
  int          n_vs   = 0;

  row_scanout_if bus();

  row_scanout #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .FIELD_W    (FW),
    .BORDER_RGB (BORDER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int hp(int c);
    return c % HT;
  endfunction

  function automatic int vp(int c);
    return (c / HT) % VT;
  endfunction

  function automatic bit vis_at(int c);
    return (hp(c) < HA) && (vp(c) < VA);
  endfunction

  function automatic bit fld_at(int c);
    return vis_at(c) && (hp(c) < FW);
  endfunction

  function automatic bit hs_at(int c);
    return !((hp(c) >= HA + HF) && (hp(c) < HA + HF + HS));
  endfunction

  function automatic bit vs_at(int c);
    return !((vp(c) >= VA + VF) && (vp(c) < VA + VF + VS));
  endfunction

  function automatic bit swap_at(int c);
    return (hp(c) == HA + 2) && ((vp(c) <= VA - 2) || (vp(c) == VT - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (epoch %0d k %0d)", name, act, exp, epoch, k);
  endtask

  // Row RAM with registered read, a drawer that refills the bank it is handed,
  // and the reference raster position k (cycles since reset release).
  always @(posedge clk) begin
    bus.row_data <= mem[bus.bank_sel][bus.row_addr];
    if (bus.clr_wren) mem[bus.bank_sel][bus.clr_addr] <= '0;
    if (!rst_n) begin
      k     = 0;
      mbank = 1'b0;
      for (int a = 0; a < 512; a++) begin
        mem[0][a] <= 24'(a);
        mem[1][a] <= 24'($urandom);
      end
    end else begin
      rd_hist[k % 4] = mem[mbank][(hp(k) < FW) ? hp(k) : 0];
      k = k + 1;
      if (swap_at(k)) begin
        mbank = ~mbank;
        for (int a = 0; a < FW; a++) mem[~mbank][a] <= 24'($urandom);
      end
    end
  end

  initial begin
    int          p;
    logic [23:0] e_rgb;
    logic        e_de;
    logic        e_hs;
    logic        e_vs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_row_addr", 32'(bus.row_addr), 0);
        chk("rst_swap", 32'(bus.swap), 0);
        chk("rst_bank_sel", 32'(bus.bank_sel), 0);
        chk("rst_frame_start", 32'(bus.frame_start), 0);
        chk("rst_rgb", 32'(bus.vga_rgb), 0);
        chk("rst_hs", 32'(bus.vga_hs), 1);
        chk("rst_vs", 32'(bus.vga_vs), 1);
        chk("rst_de", 32'(bus.vga_de), 0);
        chk("rst_clr_wren", 32'(bus.clr_wren), 0);
        chk("rst_clr_addr", 32'(bus.clr_addr), 0);
      end else begin
        chk("row_addr", 32'(bus.row_addr), (hp(k) < FW) ? hp(k) : 0);
        chk("swap", 32'(bus.swap), 32'(swap_at(k)));
        chk("bank_sel", 32'(bus.bank_sel), 32'(mbank));
        chk("frame_start", 32'(bus.frame_start),
            32'((k > 0) && (hp(k) == 0) && (vp(k) == 0)));
        if (k >= 2) begin
          p     = k - 2;
          e_rgb = fld_at(p) ? rd_hist[p % 4] : (vis_at(p) ? BORDER : 24'h0);
          e_de  = vis_at(p);
          e_hs  = hs_at(p);
          e_vs  = vs_at(p);
        end else begin
          e_rgb = 24'h0;
          e_de  = 1'b0;
          e_hs  = 1'b1;
          e_vs  = 1'b1;
        end
        chk("vga_rgb", 32'(bus.vga_rgb), 32'(e_rgb));
        chk("vga_de", 32'(bus.vga_de), 32'(e_de));
        chk("vga_hs", 32'(bus.vga_hs), 32'(e_hs));
        chk("vga_vs", 32'(bus.vga_vs), 32'(e_vs));
`ifdef SCANOUT_CLEAR_EN
        chk("clr_wren", 32'(bus.clr_wren), 32'((k >= 1) && fld_at(k - 1)));
        if ((k >= 1) && fld_at(k - 1)) chk("clr_addr", 32'(bus.clr_addr), hp(k - 1));
`else
        chk("clr_wren", 32'(bus.clr_wren), 0);
        chk("clr_addr", 32'(bus.clr_addr), 0);
`endif
        // Hand-computed anchors for the first frame after power-up.
        if (epoch == 0) begin
          if (k < FRAME) begin
            n_swap += int'(bus.swap);
            n_de   += int'(bus.vga_de);
            n_hs   += int'(!bus.vga_hs);
            n_vs   += int'(!bus.vga_vs);
          end
          if (k == 7) chk("lit_pixel5", 32'(bus.vga_rgb), 32'h000005);
          if (k == FW + 2) chk("lit_border", 32'(bus.vga_rgb), 32'h202020);
          if (k == HA + 2) begin
            chk("lit_blank_rgb", 32'(bus.vga_rgb), 0);
            chk("lit_swap_642", 32'(bus.swap), 1);
            chk("lit_bank_after", 32'(bus.bank_sel), 1);
          end
          if (k == HA + HF + 1) chk("lit_hs_before", 32'(bus.vga_hs), 1);
          if (k == HA + HF + 2) chk("lit_hs_start", 32'(bus.vga_hs), 0);
          if (k == FRAME) begin
            chk("lit_swaps_per_frame", n_swap, 12);
            chk("lit_de_per_frame", n_de, 480);
            chk("lit_hs_low_cycles", n_hs, 152);
            chk("lit_vs_low_cycles", n_vs, 116);
            chk("lit_frame_period", 32'(bus.frame_start), 1);
          end
        end else begin
          if (k == HA + 1) chk("lit_bank_pre_swap", 32'(bus.bank_sel), 0);
          if (k == HA + 2) chk("lit_first_swap", 32'(bus.swap), 1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    // Land the reset at line 5, pixel 25 of the third frame.
    repeat (2 * FRAME + 5 * HT + 25) @(posedge clk);
    #2 rst_n = 1'b0;
    epoch = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FRAME + 100) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
